// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: queues resolved-branch BTB updates, arbitrates the shared BTB port against fetch lookups, and walks the table to invalidate it on flush.
module btb_update_ctrl #(
    parameter int LOWER      = 5,
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_lookup_req,
    output logic             o_lookup_gnt,
    input  logic             i_upd_valid,
    output logic             o_upd_ready,
    input  logic [63:0]      i_upd_pc,
    input  logic [63:0]      i_upd_target,
    input  logic             i_upd_taken,
    input  logic             i_flush_req,
    output logic             o_flush_busy,
    output logic             o_btb_en,
    output logic             o_btb_wr_en,
    output logic [LOWER-1:0] o_btb_wr_idx,
    output logic [63-LOWER:0] o_btb_wr_tag,
    output logic [63:0]      o_btb_wr_target,
    output logic             o_btb_wr_valid
);
    localparam int QW = $clog2(QDEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    typedef enum logic {IDLE, FLUSH} state_t;
    state_t r_state, w_state_nx;
    logic r_live;
    logic [63:0] r_pc [QDEPTH];
    logic [63:0] r_tgt [QDEPTH];
    logic [QDEPTH-1:0] r_tk;
    logic [QW-1:0] r_wp, r_rp;
    logic [QW:0] r_cnt;
    logic [SW-1:0] r_starve;
    logic [LOWER-1:0] r_walk;
    logic w_on, w_idle, w_empty, w_full, w_deq, w_enq, w_flush_go;
    logic [63:0] w_head_pc;
    // r_live holds every output low for the first cycle after reset releases
    assign w_on       = r_live & ~rst;
    assign w_idle     = w_on & (r_state == IDLE);
    assign w_empty    = r_cnt == '0;
    assign w_full     = r_cnt == (QW+1)'(QDEPTH);
    assign w_deq      = w_idle & ~w_empty & (~i_lookup_req | r_starve == SW'(STARVE_MAX));
    assign w_flush_go = w_on & i_flush_req;
    assign w_enq      = i_upd_valid & o_upd_ready;
    assign w_head_pc  = r_pc[r_rp];
    assign o_upd_ready = w_idle & ~w_full & ~i_flush_req;
    always_comb begin
        w_state_nx      = w_flush_go ? FLUSH : (r_state == FLUSH && r_walk == '1) ? IDLE : r_state;
        o_flush_busy    = w_on & (r_state == FLUSH);
        o_lookup_gnt    = w_idle & i_lookup_req & ~w_deq;
        o_btb_wr_en     = o_flush_busy | w_deq;
        o_btb_wr_idx    = o_flush_busy ? r_walk : w_deq ? w_head_pc[LOWER-1:0] : '0;
        o_btb_wr_tag    = w_deq ? w_head_pc[63:LOWER] : '0;
        o_btb_wr_valid  = w_deq & r_tk[r_rp];
        o_btb_wr_target = o_btb_wr_valid ? r_tgt[r_rp] : '0;
        o_btb_en        = o_lookup_gnt | o_btb_wr_en;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_live   <= 1'b0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            r_starve <= '0;
            r_walk   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_live  <= 1'b1;
            r_walk  <= w_flush_go ? '0 : r_walk + 1'b1;
            if (w_flush_go) begin
                r_wp     <= '0;
                r_rp     <= '0;
                r_cnt    <= '0;
                r_starve <= '0;
            end else begin
                r_wp     <= r_wp + QW'(w_enq);
                r_rp     <= r_rp + QW'(w_deq);
                r_cnt    <= r_cnt + (QW+1)'(w_enq) - (QW+1)'(w_deq);
                r_starve <= (w_deq | w_empty) ? '0 : r_starve + SW'(w_idle & i_lookup_req);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_pc[r_wp]  <= i_upd_pc;
            r_tgt[r_wp] <= i_upd_target;
            r_tk[r_wp]  <= i_upd_taken;
        end
    end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: directed vectors, corner-case sequences and random traffic against a queue-based reference model.
module tb_btb_update_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1, lreq = 1'b0, gnt, uv = 1'b0, rdy, utk = 1'b0, flr = 1'b0;
    logic busy, en, wr_en, vld;
    logic [63:0] upc = '0, utg = '0, wtgt;
    logic [4:0] idx;
    logic [58:0] tag;
    int n_cmp = 0, n_bad = 0;

    typedef struct packed {
        logic gnt, rdy, wr_en;
        logic [4:0] idx;
        logic [58:0] tag;
        logic [63:0] tgt;
        logic vld, busy, en;
    } out_t;
    typedef struct {logic [63:0] pc, tg; bit tk;} upd_t;
    typedef struct {bit r, l, v; logic [63:0] pc, tg; bit tk, fl; out_t exp;} vec_t;

    upd_t m_q[$];
    int m_starve = 0, m_walk = 0;
    bit m_flush = 0, m_live = 0;
    out_t act;

    btb_update_ctrl dut (
        .clk(clk), .rst(rst), .i_lookup_req(lreq), .o_lookup_gnt(gnt),
        .i_upd_valid(uv), .o_upd_ready(rdy), .i_upd_pc(upc), .i_upd_target(utg),
        .i_upd_taken(utk), .i_flush_req(flr), .o_flush_busy(busy), .o_btb_en(en),
        .o_btb_wr_en(wr_en), .o_btb_wr_idx(idx), .o_btb_wr_tag(tag),
        .o_btb_wr_target(wtgt), .o_btb_wr_valid(vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic out_t mk(bit g, bit rd, bit w, logic [4:0] ix, logic [58:0] tg,
                                logic [63:0] t, bit v, bit b, bit n);
        out_t o;
        o = '{gnt: g, rdy: rd, wr_en: w, idx: ix, tag: tg, tgt: t, vld: v, busy: b, en: n};
        return o;
    endfunction

    task automatic model_out(input bit r, input bit l, input bit fl, output out_t e);
        e = '0;
        if (!r && m_live) begin
            if (m_flush) begin
                e.wr_en = 1; e.idx = m_walk[4:0]; e.busy = 1;
            end else begin
                e.rdy = (m_q.size() < 4) && !fl;
                if (m_q.size() > 0 && (!l || m_starve == 3)) begin
                    e.wr_en = 1;
                    e.idx = m_q[0].pc[4:0];
                    e.tag = m_q[0].pc[63:5];
                    e.vld = m_q[0].tk;
                    e.tgt = m_q[0].tk ? m_q[0].tg : 64'd0;
                end else e.gnt = l;
            end
            e.en = e.gnt | e.wr_en;
        end
    endtask

    task automatic model_step(input bit r, l, v, input logic [63:0] pc, tg, input bit tk, fl,
                              input out_t e);
        bit was_empty;
        upd_t u;
        if (r) begin
            m_q.delete(); m_starve = 0; m_flush = 0; m_live = 0; m_walk = 0;
        end else if (!m_live) m_live = 1;
        else if (m_flush) begin
            if (fl) m_walk = 0;
            else if (m_walk == 31) m_flush = 0;
            else m_walk++;
        end else begin
            was_empty = m_q.size() == 0;
            if (e.wr_en) void'(m_q.pop_front());
            if (v && e.rdy) begin
                u.pc = pc; u.tg = tg; u.tk = tk;
                m_q.push_back(u);
            end
            m_starve = (e.wr_en || was_empty) ? 0 : (l ? m_starve + 1 : m_starve);
            if (fl) begin
                m_flush = 1; m_walk = 0; m_q.delete(); m_starve = 0;
            end
        end
    endtask

    task automatic cyc(input bit r, l, v, input logic [63:0] pc, tg, input bit tk, fl);
        out_t e;
        @(negedge clk);
        rst = r; lreq = l; uv = v; upc = pc; utg = tg; utk = tk; flr = fl;
        #1;
        model_out(r, l, fl, e);
        act = {gnt, rdy, wr_en, idx, tag, wtgt, vld, busy, en};
        chk("model", 256'(act), 256'(e));
        model_step(r, l, v, pc, tg, tk, fl, e);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        vec_t vt[7];
        int pushed, writes, gaps_ok, g_since, busy_n, issued, nw;
        bit saw_full, idx_ok, no_vld, rdy_after, seen_idle, no_wr;
        logic [63:0] iss[6];
        vt[0] = '{1, 0, 0, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0)};
        vt[1] = '{0, 0, 0, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0)};
        vt[2] = '{0, 0, 1, 64'h1000_0044, 64'h2000, 1, 0, mk(0,1,0,0,0,0,0,0,0)};
        vt[3] = '{0, 0, 1, 64'h7C, 64'h5555, 0, 0, mk(0,1,1,5'h04,59'h0800002,64'h2000,1,0,1)};
        vt[4] = '{0, 1, 0, 0, 0, 0, 0, mk(1,1,0,0,0,0,0,0,1)};
        vt[5] = '{0, 0, 0, 0, 0, 0, 0, mk(0,1,1,5'h1C,59'h3,0,0,0,1)};
        vt[6] = '{0, 1, 0, 0, 0, 0, 0, mk(1,1,0,0,0,0,0,0,1)};
        for (int i = 0; i < 7; i++) begin
            cyc(vt[i].r, vt[i].l, vt[i].v, vt[i].pc, vt[i].tg, vt[i].tk, vt[i].fl);
            chk($sformatf("vec%0d", i), 256'(act), 256'(vt[i].exp));
        end

        do_reset();
        pushed = 0; writes = 0; gaps_ok = 0; g_since = 0; saw_full = 0;
        for (int k = 0; k < 30; k++) begin
            cyc(0, 1, pushed < 4, 64'h100 * (pushed + 1), 64'h9000 + pushed, 1, 0);
            if (uv && act.rdy) pushed++;
            if (pushed > 0 && !act.rdy) saw_full = 1;
            if (act.wr_en) begin
                if (writes > 0 && g_since == 3) gaps_ok++;
                writes++; g_since = 0;
            end else if (act.gnt) g_since++;
        end
        chk("starve_writes", 256'(writes), 256'(4));
        chk("starve_gaps", 256'(gaps_ok), 256'(3));
        chk("starve_full", 256'(saw_full), 256'(1));

        do_reset();
        cyc(0, 1, 1, 64'hAAA0, 64'h1, 1, 0);
        cyc(0, 1, 1, 64'hBBB0, 64'h2, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 1);
        busy_n = 0; idx_ok = 1; no_vld = 1; rdy_after = 0; seen_idle = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            if (act.busy) begin
                if (act.idx != 5'(busy_n) || !act.wr_en) idx_ok = 0;
                busy_n++;
            end else if (!seen_idle) begin
                seen_idle = 1; rdy_after = act.rdy;
            end
            if (act.vld || (act.wr_en && !act.busy)) no_vld = 0;
        end
        chk("flush_len", 256'(busy_n), 256'(32));
        chk("flush_idx", 256'(idx_ok), 256'(1));
        chk("flush_novalid", 256'(no_vld), 256'(1));
        chk("flush_rdy_after", 256'(rdy_after), 256'(1));

        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0, 0, 0, 0);
        chk("walk_idx9", 256'(act.idx), 256'(9));
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("rst_walk_zero", 256'(act), 256'(0));
        no_wr = 1;
        for (int k = 0; k < 40; k++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            if (act.wr_en || act.busy) no_wr = 0;
        end
        chk("rst_walk_stops", 256'(no_wr), 256'(1));

        do_reset();
        issued = 0; nw = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(0, k < 3, issued < 6, 64'h1000 + 64'(issued) * 64'h41, 64'h7000 + 64'(issued), 1, 0);
            if (act.wr_en) begin
                if (nw < 6) chk($sformatf("fifo_order%0d", nw), 256'({act.tag, act.idx}), 256'(iss[nw]));
                nw++;
            end
            if (uv && act.rdy) begin
                iss[issued] = upc; issued++;
            end
        end
        chk("fifo_count", 256'(nw), 256'(6));

        do_reset();
        for (int k = 0; k < 4000; k++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 1), $urandom_range(0, 9) < 6,
                {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 1),
                $urandom_range(0, 149) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
